// File: rtl/vmotion_pkg.sv
// vmotion_pkg: vertical-motion state encodings and velocity width shared by motion, collision and renderer stages.
package vmotion_pkg;
   typedef enum logic [1:0] {
      ST_GROUND = 2'b00,
      ST_RISE   = 2'b01,
      ST_FALL   = 2'b10
   } vstate_e;
   localparam int VEL_W = 5;
endpackage

// File: rtl/btn_req_latch.sv
// btn_req_latch: latches a button rising edge as a request held until the next consume pulse.
module btn_req_latch (
   input  logic clk,
   input  logic resetn,
   input  logic btn,
   input  logic consume,
   output logic req
);
   logic prev_q, req_q, req_d;
   // an edge arriving on the consuming cycle survives for the following tick
   always_comb req_d = (req_q && !consume) || (btn && !prev_q);
   always_ff @(posedge clk) begin
      if (!resetn) begin
         prev_q <= 1'b0;
         req_q  <= 1'b0;
      end else begin
         prev_q <= btn;
         req_q  <= req_d;
      end
   end
   assign req = req_q;
endmodule

// File: rtl/player_vertical_ctrl.sv
// player_vertical_ctrl: tick-driven player y/velocity FSM with gravity, jump, terminal clamp and wrap scroll.
// Define GUNBOOT_EN to build the fire-to-thrust gunboot with a refillable magazine.
module player_vertical_ctrl
   import vmotion_pkg::*;
#(
   parameter logic [7:0] Y_MAX    = 8'd119,
   parameter logic [2:0] GRAVITY  = 3'd1,
   parameter logic [2:0] JUMP_VEL = 3'd4,
   parameter logic [2:0] TERM_VEL = 3'd3,
   parameter logic [2:0] THRUST   = 3'd2,
   parameter logic [3:0] MAG_SIZE = 4'd8
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       tick,
   input  logic       jump_btn,
   input  logic       fire_btn,
   input  logic       on_ground,
   input  logic [7:0] start_y,
   output logic [7:0] y_out,
   output logic [4:0] vel_out,
   output logic [1:0] state_out,
   output logic       scroll,
   output logic [3:0] ammo_out
);
   localparam logic signed [VEL_W-1:0] GRAV_S   = VEL_W'(GRAVITY);
   localparam logic signed [VEL_W-1:0] JUMP_S   = VEL_W'(JUMP_VEL);
   localparam logic signed [VEL_W-1:0] TERM_S   = VEL_W'(TERM_VEL);
   localparam logic signed [VEL_W-1:0] THRUST_S = VEL_W'(THRUST);
   logic [7:0] y_q, y_mv;
   logic signed [VEL_W-1:0] vel_q, vel_g;
   vstate_e state_q;
   logic scroll_q;
   logic [3:0] ammo_q;
   logic [8:0] ny;
   logic jump_req, shoot, wrap, land;
   btn_req_latch u_jump (
      .clk(clk), .resetn(resetn), .btn(jump_btn), .consume(tick), .req(jump_req)
   );
`ifdef GUNBOOT_EN
   localparam logic GB = 1'b1;
   logic fire_req;
   btn_req_latch u_fire (
      .clk(clk), .resetn(resetn), .btn(fire_btn), .consume(tick), .req(fire_req)
   );
   assign shoot = fire_req && ammo_q != 4'd0;
`else
   localparam logic GB = 1'b0;
   logic unused_fire;
   assign unused_fire = fire_btn;
   assign shoot = 1'b0;
`endif
   localparam logic [3:0] AMMO_FULL = GB ? MAG_SIZE : 4'd0;
   // ny is 9-bit signed; bit 8 set means the move went above row 0
   always_comb begin
      ny    = {1'b0, y_q} + {{(9-VEL_W){vel_q[VEL_W-1]}}, vel_q};
      wrap  = !ny[8] && ny[7:0] > Y_MAX;
      y_mv  = ny[8] ? 8'd0 : wrap ? ny[7:0] - (Y_MAX + 8'd1) : ny[7:0];
      vel_g = vel_q + GRAV_S;
      land  = state_q == ST_FALL && on_ground;
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         y_q      <= start_y;
         vel_q    <= '0;
         state_q  <= ST_FALL;
         scroll_q <= 1'b0;
         ammo_q   <= AMMO_FULL;
      end else begin
         scroll_q <= 1'b0;
         if (tick) begin
            if (state_q == ST_GROUND) begin
               if (!on_ground) begin
                  state_q <= ST_FALL;
                  vel_q   <= '0;
               end else if (jump_req) begin
                  state_q <= ST_RISE;
                  vel_q   <= -JUMP_S;
               end
            end else if (land) begin
               state_q <= ST_GROUND;
               vel_q   <= '0;
               ammo_q  <= AMMO_FULL;
            end else if (shoot) begin
               y_q      <= y_mv;
               scroll_q <= wrap;
               vel_q    <= -THRUST_S;
               ammo_q   <= ammo_q - 4'd1;
               state_q  <= ST_RISE;
            end else if (state_q == ST_RISE) begin
               y_q     <= y_mv;
               vel_q   <= ny[8] ? '0 : vel_g;
               state_q <= (ny[8] || !vel_g[VEL_W-1]) ? ST_FALL : ST_RISE;
            end else begin
               y_q      <= y_mv;
               scroll_q <= wrap;
               vel_q    <= vel_g > TERM_S ? TERM_S : vel_g;
            end
         end
      end
   end
   assign y_out     = y_q;
   assign vel_out   = vel_q;
   assign state_out = state_q;
   assign scroll    = scroll_q;
   assign ammo_out  = ammo_q;
endmodule

// File: tb/tb_player_vertical_ctrl.sv
// tb_player_vertical_ctrl: integer reference model checked every cycle plus hand-computed directed expectations.
module tb_player_vertical_ctrl;
`ifdef GUNBOOT_EN
   localparam bit GB = 1'b1;
`else
   localparam bit GB = 1'b0;
`endif
   localparam int AMMO_FULL = GB ? 8 : 0;
   logic clk = 1'b0, resetn = 1'b0, tick = 1'b0, jump_btn = 1'b0, fire_btn = 1'b0, on_ground = 1'b0;
   logic [7:0] start_y = 8'd10;
   logic [7:0] y_out;
   logic [4:0] vel_out;
   logic [1:0] state_out;
   logic scroll;
   logic [3:0] ammo_out;
   int n_chk = 0, n_err = 0;
   int m_y, m_v, m_st, m_sc, m_a;
   bit m_jr, m_fr, m_jp, m_fp, valid = 1'b0;
   player_vertical_ctrl dut (
      .clk(clk), .resetn(resetn), .tick(tick), .jump_btn(jump_btn), .fire_btn(fire_btn),
      .on_ground(on_ground), .start_y(start_y), .y_out(y_out), .vel_out(vel_out),
      .state_out(state_out), .scroll(scroll), .ammo_out(ammo_out)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask
   function automatic int vel_s();
      return int'($signed(vel_out));
   endfunction
   // reference model: plain integer arithmetic on the motion rules, 0=ground 1=rise 2=fall
   always @(posedge clk) begin
      bit jr, fr;
      int ny;
      if (!resetn) begin
         m_y = int'(start_y); m_v = 0; m_st = 2; m_sc = 0; m_a = AMMO_FULL;
         m_jr = 0; m_fr = 0; m_jp = 0; m_fp = 0; valid = 1'b1;
      end else begin
         jr = m_jr; fr = m_fr;
         m_jr = (m_jr && !tick) || (jump_btn && !m_jp); m_jp = jump_btn;
         m_fr = GB && ((m_fr && !tick) || (fire_btn && !m_fp)); m_fp = fire_btn;
         m_sc = 0;
         if (tick) begin
            ny = m_y + m_v;
            if (m_st == 0) begin
               if (!on_ground) begin m_st = 2; m_v = 0; end
               else if (jr) begin m_st = 1; m_v = -4; end
            end else if (m_st == 2 && on_ground) begin
               m_st = 0; m_v = 0; m_a = AMMO_FULL;
            end else if (fr && m_a > 0) begin
               m_sc = ny > 119;
               m_y = ny < 0 ? 0 : ny > 119 ? ny - 120 : ny;
               m_v = -2; m_a--; m_st = 1;
            end else if (m_st == 1) begin
               if (ny < 0) begin m_y = 0; m_v = 0; m_st = 2; end
               else begin m_y = ny; m_v++; if (m_v >= 0) m_st = 2; end
            end else begin
               m_sc = ny > 119;
               m_y = ny > 119 ? ny - 120 : ny;
               m_v = m_v + 1 > 3 ? 3 : m_v + 1;
            end
         end
      end
      #1;
      if (valid) begin
         chk("model_y", int'(y_out), m_y);
         chk("model_vel", vel_s(), m_v);
         chk("model_state", int'(state_out), m_st);
         chk("model_scroll", int'(scroll), m_sc);
         chk("model_ammo", int'(ammo_out), m_a);
      end
   end
   task automatic rst(input int y);
      start_y = 8'(y); resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask
   task automatic tk();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
   endtask
   task automatic press(input bit j, input bit f);
      jump_btn = j; fire_btn = f;
      @(negedge clk);
      jump_btn = 1'b0; fire_btn = 1'b0;
      @(negedge clk);
   endtask
   initial begin
      int ys1[5] = '{10, 11, 13, 16, 19};
      int ys2[4] = '{46, 43, 41, 40};
      int st2[4] = '{1, 1, 1, 2};
      @(negedge clk);
      rst(10);
      chk("reset_y", int'(y_out), 10);
      chk("reset_vel", vel_s(), 0);
      chk("reset_state", int'(state_out), 2);
      chk("reset_scroll", int'(scroll), 0);
      chk("reset_ammo", int'(ammo_out), AMMO_FULL);
      for (int i = 0; i < 5; i++) begin
         tk();
         chk("fall_y", int'(y_out), ys1[i]);
      end
      chk("fall_vel_cap", vel_s(), 3);
      rst(50); on_ground = 1'b1;
      tk();
      chk("land_state", int'(state_out), 0);
      chk("land_y", int'(y_out), 50);
      press(1, 0);
      tk();
      chk("jump_state", int'(state_out), 1);
      chk("jump_vel", vel_s(), -4);
      chk("jump_y", int'(y_out), 50);
      for (int i = 0; i < 4; i++) begin
         tk();
         chk("rise_y", int'(y_out), ys2[i]);
         chk("rise_state", int'(state_out), st2[i]);
      end
      tk();
      chk("reland_state", int'(state_out), 0);
      press(1, 1);
      tk();
      chk("both_ground_vel", vel_s(), -4);
      press(1, 1);
      tk();
      chk("both_air_y", int'(y_out), 36);
      chk("both_air_vel", vel_s(), GB ? -2 : -3);
      on_ground = 1'b0;
      rst(115);
      repeat (3) tk();
      chk("pre_wrap_y", int'(y_out), 118);
      chk("pre_wrap_vel", vel_s(), 3);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk("wrap_y", int'(y_out), 1);
      chk("wrap_scroll_hi", int'(scroll), 1);
      @(negedge clk);
      chk("wrap_scroll_lo", int'(scroll), 0);
      rst(2); on_ground = 1'b1;
      tk();
      press(1, 0);
      tk();
      chk("top_pre_y", int'(y_out), 2);
      tk();
      chk("top_clamp_y", int'(y_out), 0);
      chk("top_clamp_vel", vel_s(), 0);
      chk("top_clamp_state", int'(state_out), 2);
      rst(50);
      tk();
      press(1, 0);
      tk(); tk();
      chk("mid_rise_y", int'(y_out), 46);
      start_y = 8'd70; resetn = 1'b0; tick = 1'b1;
      @(negedge clk);
      resetn = 1'b1; tick = 1'b0;
      chk("rst_tick_y", int'(y_out), 70);
      chk("rst_tick_vel", vel_s(), 0);
      chk("rst_tick_state", int'(state_out), 2);
      on_ground = 1'b0;
      rst(115);
      repeat (3) tk();
      start_y = 8'd5; resetn = 1'b0; tick = 1'b1;
      @(negedge clk);
      resetn = 1'b1; tick = 1'b0;
      chk("rst_wrap_scroll", int'(scroll), 0);
      chk("rst_wrap_y", int'(y_out), 5);
      @(negedge clk);
      chk("rst_wrap_scroll2", int'(scroll), 0);
      rst(20);
      repeat (3) tk();
      press(0, 1);
      tk();
      chk("shot_y", int'(y_out), 26);
      chk("shot_vel", vel_s(), GB ? -2 : 3);
      chk("shot_ammo", int'(ammo_out), GB ? 7 : 0);
      chk("shot_state", int'(state_out), GB ? 1 : 2);
      if (GB) begin
         repeat (8) begin
            press(0, 1);
            tk();
         end
         chk("empty_ammo", int'(ammo_out), 0);
         chk("empty_y", int'(y_out), 10);
         chk("empty_vel", vel_s(), -1);
         tk();
         on_ground = 1'b1;
         tk();
         chk("refill_ammo", int'(ammo_out), 8);
         chk("refill_state", int'(state_out), 0);
      end
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
